// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle EXEC path for logic/arith/shift ops, optional iterative multiplier.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier (op 110); otherwise op 110 yields zero.
module alu_seq #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   ALUop,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic [2:0]   Z
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastIter = CW'(W - 1);
`else
  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
`endif

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   out_q, out_d;
  logic [2:0]     z_q, z_d;
  logic [W-1:0]   res, sum, diff;
  logic           ovf;

`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_nxt;

  // b_q doubles as the multiplier shift register; its LSB gates each partial product.
  assign acc_nxt = b_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (op_q)
      3'b000: begin
        res = sum;
        ovf = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      3'b001: begin
        res = diff;
        ovf = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      3'b010: res = a_q & b_q;
      3'b011: res = ~b_q;
      3'b100: res = a_q | b_q;
      3'b101: res = a_q ^ b_q;
      3'b110: res = '0;
      3'b111: res = W'($signed(a_q) >>> b_q[3:0]);
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    z_d     = z_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = ALUop;
          a_d     = Ain;
          b_d     = Bin;
          state_d = StExec;
`ifdef ALU_SEQ_MUL_EN
          if (ALUop == 3'b110) begin
            state_d = StMul;
            acc_d   = '0;
            mcand_d = {{W{1'b0}}, Ain};
            cnt_d   = '0;
          end
`endif
        end
      end
      StExec: begin
        out_d   = res;
        z_d     = {res == '0, ovf, res[W-1]};
        state_d = StDone;
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastIter) begin
          out_d   = acc_nxt[W-1:0];
          z_d     = {acc_nxt[W-1:0] == '0, |acc_nxt[2*W-1:W], acc_nxt[W-1]};
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      z_q     <= 3'b100;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      z_q     <= z_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign out  = out_q;
  assign Z    = z_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter W, default 16, datapath width in bits (W >= 4).
REQ-002 SHALL have port clk input 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-004 SHALL have port start input 1: request; sampled only in IDLE.
REQ-005 SHALL have port ALUop input 3: operation code, captured on the accepted start.
REQ-006 SHALL have port Ain input W: operand A, captured on the accepted start.
REQ-007 SHALL have port Bin input W: operand B, captured on the accepted start.
REQ-008 SHALL have port busy output 1: high while an operation is in flight; start ignored.
REQ-009 SHALL have port done output 1: one-cycle pulse when out and Z update.
REQ-010 SHALL have port out output W: registered result, held until the next done.
REQ-011 SHALL have port Z output 3: registered flags {zero, overflow, negative}, updated with out.

Function
REQ-012 SHALL decode ALUop as: 000 add, 001 sub, 010 AND, 011 NOT B, 100 OR, 101 XOR, 110 unsigned multiply, 111 arithmetic shift right of A by Bin[3:0].
REQ-013 SHALL implement states IDLE, EXEC, MUL, DONE; start=1 in IDLE is accepted and captures operands and opcode.
REQ-014 SHALL go IDLE->MUL for op 110 and IDLE->EXEC for all other ops; EXEC->DONE after 1 cycle; MUL->DONE after W iteration cycles; DONE->IDLE after 1 cycle.
REQ-015 SHALL assert busy in EXEC, MUL and DONE, and deassert it in IDLE.
REQ-016 SHALL raise done for exactly one cycle while in DONE, with out and Z valid in that same cycle.
REQ-017 SHALL give latency from the start-sampling edge to done of 2 cycles for non-multiply ops and W+1 cycles for multiply.
REQ-018 SHALL compute add and sub modulo 2^W, with overflow=1 when the operand signs imply a signed two's-complement overflow.
REQ-019 SHALL compute multiply by iterative shift-add, one multiplier bit per cycle, into a 2W-bit accumulator; out = low W bits; overflow=1 when any high W bit is nonzero.
REQ-020 SHALL force overflow=0 for ops 010, 011, 100, 101 and 111.
REQ-021 SHALL set zero=1 when out is all zeros and negative = out[W-1], for every op.
REQ-022 SHALL ignore start in any non-IDLE state without corrupting the in-flight operation.
REQ-023 SHALL accept a start held continuously high as back-to-back requests, each sampled on re-entry to IDLE.
REQ-024 SHALL read ALUop, Ain and Bin only on the accepted start; later operand changes SHALL have no effect.
REQ-025 SHALL return a shift result of A for a shift amount of 0, and sign fill for shift amounts at or above W-1.

Reset
REQ-026 SHALL, on reset=1, immediately force state IDLE, busy=0, done=0, out=0, Z=3'b100, and clear the accumulator and iteration counter, independent of clk.
REQ-027 SHALL abandon any operation interrupted by reset, producing no done pulse for it; the first start after reset release SHALL be accepted normally.

Configuration
REQ-028 SHALL, when macro ALU_SEQ_MUL_EN is defined, implement op 110 as specified in REQ-014 and REQ-019.
REQ-029 SHALL, when ALU_SEQ_MUL_EN is undefined, omit the MUL state and multiplier datapath; op 110 then takes the EXEC path and yields out=0, Z=3'b100.

Verification
REQ-030 SHALL verify W=16, op 000, A=16'h7FFF, B=16'h0001 -> done at start+2, out=16'h8000, Z=3'b011.
REQ-031 SHALL verify op 001, A=16'h0005, B=16'h0005 -> out=16'h0000, Z=3'b100; op 011, B=16'h00FF -> out=16'hFF00, Z=3'b001.
REQ-032 SHALL verify with ALU_SEQ_MUL_EN defined: op 110, A=16'h0100, B=16'h0100 -> done at start+17, out=16'h0000, Z=3'b110; A=3, B=7 -> out=21, Z=3'b000.
REQ-033 SHALL verify op 111, A=16'h8000, Bin[3:0]=4 -> out=16'hF800, Z=3'b001; start pulsed while busy -> ignored, single done.
REQ-034 SHALL verify reset asserted mid-multiply (cycle 5) -> busy=0, out=0 asynchronously, no done; next start op 000, 2+2 -> out=4 at start+2.
REQ-035 SHALL verify without ALU_SEQ_MUL_EN: op 110, A=3, B=7 -> done at start+2, out=0, Z=3'b100.
